// File: rtl/decode_fold.sv
// decode_fold
//   Streaming instruction decoder for the bfX core. Each accepted beat is
//   classified as dataCounter, data, io, branch or stop. A run of identical
//   foldable codes (0x0..0x3) collapses into one op that carries a repeat
//   count. After a stop is accepted the decoder halts until reset.
//
//   Two registered stages:
//     accumulator  (acc_v_q, acc_c_q, acc_cnt_q) - the op being built
//     output reg   (op_*_q)                      - the op shown to the consumer
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   ix_valid/ix      instruction offer; only ix[3:0] is decoded
//   ix_ready         beat is accepted this cycle
//   flush            forces a pending foldable op out of the accumulator
//   op_valid/ready   output handshake
//   op_class         0 dataCounter, 1 data, 2 io, 3 branch
//   op_mode          ix[0] of the op
//   op_stop          op is the stop instruction
//   op_count         number of folded instructions (1 .. 2^CNT_W-1)
//   illegal          one-cycle pulse after an illegal code is accepted
//   halted           a stop has been accepted
module decode_fold #(
    parameter int unsigned IX_W  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ix_valid,
    input  logic [IX_W-1:0]  ix,
    output logic             ix_ready,
    input  logic             flush,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op_class,
    output logic             op_mode,
    output logic             op_stop,
    output logic [CNT_W-1:0] op_count,
    output logic             illegal,
    output logic             halted
);

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_e;

    state_e             state_q, state_d;

    logic               acc_v_q, acc_v_d;
    logic [3:0]         acc_c_q, acc_c_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

    logic               op_valid_q, op_valid_d;
    logic [1:0]         op_class_q, op_class_d;
    logic               op_mode_q, op_mode_d;
    logic               op_stop_q, op_stop_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic               illegal_q, illegal_d;

    logic [3:0]         code;
    logic               code_fold, code_illegal, code_stop;
    logic               acc_fold, cnt_max, out_free, merge, run;
    logic               accept, take_legal, load, drain, xfer;
    logic               unused_ix_hi;

    assign code         = ix[3:0];
    assign unused_ix_hi = ^ix[IX_W-1:4];

    always_comb begin
        code_fold    = (code[3:2] == 2'b00);
        code_illegal = (code > 4'h8);
        code_stop    = (code == 4'h8);
        acc_fold     = (acc_c_q[3:2] == 2'b00);
        cnt_max      = &acc_cnt_q;
        out_free     = ~op_valid_q | op_ready;
        merge        = acc_v_q & code_fold & (code == acc_c_q) & ~cnt_max;
        run          = (state_q == S_RUN);

        // Illegal codes are always accepted (and dropped) so they never stall
        ix_ready     = ~rst & run & (merge | ~acc_v_q | out_free | code_illegal);
        accept       = ix_valid & ix_ready;
        take_legal   = accept & ~code_illegal;
        load         = take_legal & ~merge;

        // Drain without a legal beat: foldable ops wait for flush unless halted
        drain        = ~take_legal & acc_v_q & out_free & (~run | ~acc_fold | flush);
        // A load with a full accumulator implies out_free through ix_ready
        xfer         = (load & acc_v_q) | drain;
    end

    always_comb begin
        state_d    = state_q;
        acc_v_d    = acc_v_q;
        acc_c_d    = acc_c_q;
        acc_cnt_d  = acc_cnt_q;
        op_valid_d = op_valid_q;
        op_class_d = op_class_q;
        op_mode_d  = op_mode_q;
        op_stop_d  = op_stop_q;
        op_count_d = op_count_q;
        illegal_d  = accept & code_illegal;

        if (take_legal & merge) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end else if (load) begin
            acc_v_d   = 1'b1;
            acc_c_d   = code;
            acc_cnt_d = CNT_W'(1);
        end else if (drain) begin
            acc_v_d   = 1'b0;
        end

        if (xfer) begin
            op_valid_d = 1'b1;
            op_class_d = acc_c_q[2:1];
            op_mode_d  = acc_c_q[0];
            op_stop_d  = (acc_c_q == 4'h8);
            op_count_d = acc_cnt_q;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end

        if (load & code_stop) begin
            state_d = S_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            acc_v_q    <= 1'b0;
            acc_c_q    <= '0;
            acc_cnt_q  <= '0;
            op_valid_q <= 1'b0;
            op_class_q <= '0;
            op_mode_q  <= 1'b0;
            op_stop_q  <= 1'b0;
            op_count_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_v_q    <= acc_v_d;
            acc_c_q    <= acc_c_d;
            acc_cnt_q  <= acc_cnt_d;
            op_valid_q <= op_valid_d;
            op_class_q <= op_class_d;
            op_mode_q  <= op_mode_d;
            op_stop_q  <= op_stop_d;
            op_count_q <= op_count_d;
            illegal_q  <= illegal_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_class = op_class_q;
    assign op_mode  = op_mode_q;
    assign op_stop  = op_stop_q;
    assign op_count = op_count_q;
    assign illegal  = illegal_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_decode_fold.sv
module tb_decode_fold;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ix_valid = 1'b0;
    logic [7:0] ix = '0;
    logic       flush = 1'b0;
    logic       op_ready = 1'b0;

    logic       ix_ready, op_valid, op_mode, op_stop, illegal, halted;
    logic [1:0] op_class;
    logic [7:0] op_count;

    logic       b_ix_ready, b_op_valid, b_op_mode, b_op_stop, b_illegal, b_halted;
    logic [1:0] b_op_class;
    logic [1:0] b_op_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ill_cnt  = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    decode_fold #(.IX_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .ix_valid(ix_valid), .ix(ix), .ix_ready(ix_ready),
        .flush(flush), .op_valid(op_valid), .op_ready(op_ready), .op_class(op_class),
        .op_mode(op_mode), .op_stop(op_stop), .op_count(op_count),
        .illegal(illegal), .halted(halted)
    );

    decode_fold #(.IX_W(8), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .ix_valid(ix_valid), .ix(ix), .ix_ready(b_ix_ready),
        .flush(flush), .op_valid(b_op_valid), .op_ready(op_ready), .op_class(b_op_class),
        .op_mode(b_op_mode), .op_stop(b_op_stop), .op_count(b_op_count),
        .illegal(b_illegal), .halted(b_halted)
    );

    // Inputs change 1 time unit after posedge, so negedge values are what the
    // next posedge will see.
    always @(negedge clk) begin
        if (op_valid && op_ready)
            qa.push_back({op_stop ? 8'h80 : {5'b0, op_class, op_mode}, op_count});
        if (b_op_valid && op_ready)
            qb.push_back({b_op_stop ? 8'h80 : {5'b0, b_op_class, b_op_mode}, 8'(b_op_count)});
        if (illegal)
            ill_cnt++;
    end

    function automatic logic [15:0] rec(input bit stop, input logic [1:0] cls,
                                        input bit mode, input int unsigned cnt);
        return stop ? {8'h80, 8'(cnt)} : {5'b0, cls, mode, 8'(cnt)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cmp_ops(input string tag, input bit use_b);
        int unsigned n = use_b ? qb.size() : qa.size();
        check({tag, "_nops"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_op%0d", tag, i), use_b ? qb[i] : qa[i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_ix_ready", ix_ready, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    task automatic send(input logic [7:0] code);
        int unsigned n = 0;
        bit done = 0;
        ix_valid = 1'b1;
        ix = code;
        while (!done && n < 50) begin
            @(negedge clk);
            done = ix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        ix_valid = 1'b0;
        if (!done)
            check("send_timeout", 0, 1);
    endtask

    initial begin
        // Fold of four data beats, then stop and halt
        op_ready = 1'b1;
        do_reset();
        send(8'h02); send(8'h02); send(8'h02); send(8'h02); send(8'h08);
        idle(4);
        exp_q.push_back(rec(0, 2'd1, 0, 4));
        exp_q.push_back(rec(1, 2'd0, 0, 1));
        cmp_ops("fold4", 0);
        check("halted", halted, 1);
        ix_valid = 1'b1; ix = 8'h02;
        @(negedge clk);
        check("halt_ix_ready", ix_ready, 0);
        @(posedge clk); #1;
        ix_valid = 1'b0;

        // Mode change breaks the fold
        do_reset();
        send(8'h00); send(8'h01); send(8'h00);
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        idle(3);
        exp_q.push_back(rec(0, 2'd0, 0, 1));
        exp_q.push_back(rec(0, 2'd0, 1, 1));
        exp_q.push_back(rec(0, 2'd0, 0, 1));
        cmp_ops("modechg", 0);

        // Saturation on the 2-bit counter instance
        do_reset();
        repeat (5) send(8'h03);
        send(8'h08);
        idle(4);
        exp_q.push_back(rec(0, 2'd1, 1, 3));
        exp_q.push_back(rec(0, 2'd1, 1, 2));
        exp_q.push_back(rec(1, 2'd0, 0, 1));
        cmp_ops("sat_b", 1);
        exp_q.push_back(rec(0, 2'd1, 1, 5));
        exp_q.push_back(rec(1, 2'd0, 0, 1));
        cmp_ops("nosat_a", 0);

        // Backpressure: first op held, ready falls, then drains in order
        op_ready = 1'b0;
        do_reset();
        send(8'h04); send(8'h06);
        ix_valid = 1'b1; ix = 8'h07;
        @(negedge clk);
        check("bp_ix_ready", ix_ready, 0);
        check("bp_valid", op_valid, 1);
        check("bp_class", op_class, 2);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_hold_ready", ix_ready, 0);
        check("bp_hold", {op_class, op_mode, op_count}, {2'd2, 1'b0, 8'd1});
        @(posedge clk); #1;
        op_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", ix_ready, 1);
        @(posedge clk); #1;
        ix_valid = 1'b0;
        idle(4);
        exp_q.push_back(rec(0, 2'd2, 0, 1));
        exp_q.push_back(rec(0, 2'd3, 0, 1));
        exp_q.push_back(rec(0, 2'd3, 1, 1));
        cmp_ops("bp", 0);

        // Illegal code inside a fold does not break it
        do_reset();
        ill_cnt = 0;
        send(8'h02); send(8'h0A); send(8'h02); send(8'h05);
        idle(4);
        exp_q.push_back(rec(0, 2'd1, 0, 2));
        exp_q.push_back(rec(0, 2'd2, 1, 1));
        cmp_ops("illegal", 0);
        check("illegal_pulse", ill_cnt, 1);

        // Flush closes an open fold; upper instruction bits are ignored
        do_reset();
        send(8'h00); send(8'hF0); send(8'h00);
        idle(3);
        check("noflush_nops", qa.size(), 0);
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        idle(2);
        exp_q.push_back(rec(0, 2'd0, 0, 3));
        cmp_ops("flush", 0);

        // Reset mid-fold discards everything
        do_reset();
        send(8'h00); send(8'h00);
        do_reset();
        flush = 1'b1;
        idle(3);
        flush = 1'b0;
        idle(2);
        check("rstmid_nops", qa.size(), 0);
        check("rstmid_op_valid", op_valid, 0);
        check("rstmid_halted", halted, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
